// File: rtl/bitonic_pkg.sv
// Shared constants, types and stage-table helpers for the 8-element bitonic sorter.
package bitonic_pkg;

    localparam int ELEM_W   = 32;
    localparam int N_ELEM   = 8;
    localparam int N_STAGES = 6;

    typedef logic [ELEM_W-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SORT,
        STORE
    } state_t;

    // Bitonic merge schedule: block size k and pair distance j for each stage.
    localparam logic [3:0] STAGE_K [N_STAGES] = '{4'd2, 4'd4, 4'd4, 4'd8, 4'd8, 4'd8};
    localparam logic [2:0] STAGE_J [N_STAGES] = '{3'd1, 3'd2, 3'd1, 3'd4, 3'd2, 3'd1};

    // Block size k of a stage; codes past the last stage alias the final stage.
    function automatic logic [3:0] stage_k(input logic [2:0] s);
        case (s)
            3'd0:    return STAGE_K[0];
            3'd1:    return STAGE_K[1];
            3'd2:    return STAGE_K[2];
            3'd3:    return STAGE_K[3];
            3'd4:    return STAGE_K[4];
            default: return STAGE_K[5];
        endcase
    endfunction

    // Pair distance j of a stage; codes past the last stage alias the final stage.
    function automatic logic [2:0] stage_j(input logic [2:0] s);
        case (s)
            3'd0:    return STAGE_J[0];
            3'd1:    return STAGE_J[1];
            3'd2:    return STAGE_J[2];
            3'd3:    return STAGE_J[3];
            3'd4:    return STAGE_J[4];
            default: return STAGE_J[5];
        endcase
    endfunction

    // Lower index of the p-th pair: insert a zero at the bit position of j.
    function automatic logic [2:0] pair_lo(input logic [1:0] p, input logic [2:0] j);
        case (j)
            3'd1:    return {p, 1'b0};
            3'd2:    return {p[1], 1'b0, p[0]};
            default: return {1'b0, p};
        endcase
    endfunction

endpackage

// File: rtl/bitonic_sort8_cmp_swap.sv
// Single compare-exchange cell: lo_o goes to the lower array index, hi_o to the upper.
// dir_i=1 orders ascending (lo_o <= hi_o), dir_i=0 descending. Equal inputs never swap.
module bitonic_cmp_swap #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              dir_i,
    input  logic              signed_cmp_i,
    output logic [DATA_W-1:0] lo_o,
    output logic [DATA_W-1:0] hi_o
);

    logic a_gt_b;
    logic a_lt_b;
    logic swap;

    // Strict comparisons so that equal elements stay where they are.
    // NOTE: every output of a combinational block is assigned on every path to avoid latches.
    always_comb begin
        if (signed_cmp_i) begin
            a_gt_b = $signed(a_i) > $signed(b_i);
            a_lt_b = $signed(a_i) < $signed(b_i);
        end else begin
            a_gt_b = a_i > b_i;
            a_lt_b = a_i < b_i;
        end
        swap = dir_i ? a_gt_b : a_lt_b;
        lo_o = swap ? b_i : a_i;
        hi_o = swap ? a_i : b_i;
    end

endmodule

// File: rtl/bitonic_sort8_csr.sv
// CSR-bus slave holding an 8-word input list, a bitonic sorter running one stage
// per clock, and the 8-word sorted output list.
module bitonic_sort8_csr
    import bitonic_pkg::*;
#(
    parameter int DATA_W     = ELEM_W,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        busy_o,
    output logic        done_o
);

    state_t            state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic              load_en, sort_en, store_en;

    logic [DATA_W-1:0] in_list_q  [N_ELEM];
    logic [DATA_W-1:0] out_list_q [N_ELEM];
    logic [DATA_W-1:0] work_q     [N_ELEM];
    logic [DATA_W-1:0] work_sorted[N_ELEM];

    logic              ack_q, resp_q, done_q, rd_pend_q;
    logic [4:0]        rd_addr_q;
    logic [31:0]       rdata_q;

    logic              accept, wr_in, trig;
    logic [2:0]        wr_idx;
    logic [31:0]       cur_word, merged_word, rd_word;

    logic [2:0]        lo_idx [4];
    logic [2:0]        hi_idx [4];
    logic              dir    [4];
    logic [DATA_W-1:0] cs_lo  [4];
    logic [DATA_W-1:0] cs_hi  [4];

    logic              unused_addr;
    assign unused_addr = ^bus_addr_bi[31:5];

    // A request is taken only in IDLE and not in the cycle its ack is showing.
    assign accept = (state_q == IDLE) && bus_req_i && !ack_q;
    assign wr_idx = bus_addr_bi[2:0];
    assign wr_in  = accept && bus_we_i && (bus_addr_bi[4:3] == 2'b10);
    assign trig   = wr_in && (wr_idx == 3'd7);

    assign bus_ack_o    = ack_q;
    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;

    // FSM state and stage counter register.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
        end
    end

    // Next-state logic and datapath enables for LOAD / SORT / STORE.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        load_en  = 1'b0;
        sort_en  = 1'b0;
        store_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                stage_d = '0;
                state_d = SORT;
            end
            SORT: begin
                sort_en = 1'b1;
                if (stage_q == 3'(N_STAGES - 1)) begin
                    state_d = STORE;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            STORE: begin
                store_en = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pair indices and directions of the current stage.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            lo_idx[p] = pair_lo(2'(p), stage_j(stage_q));
            hi_idx[p] = lo_idx[p] ^ stage_j(stage_q);
            dir[p]    = (({1'b0, lo_idx[p]} & stage_k(stage_q)) == 4'd0);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cs
        bitonic_cmp_swap #(.DATA_W(DATA_W)) u_cs (
            .a_i         (work_q[lo_idx[g]]),
            .b_i         (work_q[hi_idx[g]]),
            .dir_i       (dir[g]),
            .signed_cmp_i(SIGNED_CMP),
            .lo_o        (cs_lo[g]),
            .hi_o        (cs_hi[g])
        );
    end

    // Working array after applying the four compare-exchanges of this stage.
    always_comb begin
        work_sorted = work_q;
        for (int p = 0; p < 4; p++) begin
            work_sorted[lo_idx[p]] = cs_lo[p];
            work_sorted[hi_idx[p]] = cs_hi[p];
        end
    end

    // Byte-enable merge of write data into the addressed input-list word.
    always_comb begin
        cur_word = 32'(in_list_q[wr_idx]);
        for (int b = 0; b < 4; b++) begin
            merged_word[8*b +: 8] = bus_be_bi[b] ? bus_wdata_bi[8*b +: 8] : cur_word[8*b +: 8];
        end
    end

    // Read mux for the address latched at accept time; low window reads as zero.
    always_comb begin
        case (rd_addr_q[4:3])
            2'b10:   rd_word = 32'(in_list_q[rd_addr_q[2:0]]);
            2'b11:   rd_word = 32'(out_list_q[rd_addr_q[2:0]]);
            default: rd_word = '0;
        endcase
    end

    // Bus handshake: registered ack, read response one cycle after ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            resp_q    <= 1'b0;
            rdata_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            ack_q     <= accept;
            rd_pend_q <= accept && !bus_we_i;
            resp_q    <= rd_pend_q;
            if (accept) begin
                rd_addr_q <= bus_addr_bi[4:0];
            end
            if (rd_pend_q) begin
                rdata_q <= rd_word;
            end
        end
    end

    // Input list writes, working array load/sort, output list store and done pulse.
    // NOTE: the lists are register arrays that must read back as zero after reset, so they are reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_list_q  <= '{default: '0};
            out_list_q <= '{default: '0};
            work_q     <= '{default: '0};
            done_q     <= 1'b0;
        end else begin
            done_q <= store_en;
            if (wr_in) begin
                in_list_q[wr_idx] <= DATA_W'(merged_word);
            end
            if (load_en) begin
                work_q <= in_list_q;
            end else if (sort_en) begin
                work_q <= work_sorted;
            end
            if (store_en) begin
                out_list_q <= work_q;
            end
        end
    end

endmodule

// File: tb/tb_bitonic_sort8_csr.sv
// Directed bench for bitonic_sort8_csr: an unsigned and a signed instance share one bus.
module tb_bitonic_sort8_csr;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        bus_req_i = 1'b0;
    logic        bus_we_i = 1'b0;
    logic [31:0] bus_addr_bi = '0;
    logic [3:0]  bus_be_bi = '0;
    logic [31:0] bus_wdata_bi = '0;

    logic        ack_o, resp_o, busy_o, done_o;
    logic [31:0] rdata_o;
    logic        ack_s, resp_s, busy_s, done_s;
    logic [31:0] rdata_s;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    bitonic_sort8_csr #(.DATA_W(32), .SIGNED_CMP(1'b0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus_req_i(bus_req_i), .bus_we_i(bus_we_i),
        .bus_addr_bi(bus_addr_bi), .bus_be_bi(bus_be_bi), .bus_wdata_bi(bus_wdata_bi),
        .bus_ack_o(ack_o), .bus_resp_o(resp_o), .bus_rdata_bo(rdata_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    bitonic_sort8_csr #(.DATA_W(32), .SIGNED_CMP(1'b1)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .bus_req_i(bus_req_i), .bus_we_i(bus_we_i),
        .bus_addr_bi(bus_addr_bi), .bus_be_bi(bus_be_bi), .bus_wdata_bi(bus_wdata_bi),
        .bus_ack_o(ack_s), .bus_resp_o(resp_s), .bus_rdata_bo(rdata_s),
        .busy_o(busy_s), .done_o(done_s)
    );

    // Write with a bounded wait for ack; returns the cycle in which ack was seen.
    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] be, output int ack_cyc);
        bit ok = 0;
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = {27'd0, addr};
        bus_be_bi = be; bus_wdata_bi = data;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk_i); #1;
            if (ack_o) begin ok = 1; break; end
        end
        ack_cyc = cyc;
        bus_req_i = 1'b0; bus_we_i = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL write_ack addr=%h: no ack within 50 cycles", addr);
        end
    endtask

    // Read with a bounded wait for ack; data of both instances sampled on the resp cycle.
    task automatic bus_read(input logic [4:0] addr, output logic [31:0] d, output logic [31:0] d_s);
        bit ok = 0;
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = {27'd0, addr}; bus_be_bi = 4'hF;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk_i); #1;
            if (ack_o) begin ok = 1; break; end
        end
        bus_req_i = 1'b0;
        @(posedge clk_i); #1;
        d = rdata_o; d_s = rdata_s;
        checks++;
        if (!ok || !resp_o) begin
            errors++;
            $display("FAIL read_handshake addr=%h: ack=%0d resp=%0b expected ack and resp", addr, ok, resp_o);
        end
    endtask

    // Waits for done_o with a cycle budget; checks latency from ack and the pulse width.
    task automatic wait_done(input int ack_cyc, input string name);
        bit ok = 0;
        int lat;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk_i); #1;
            if (done_o) begin ok = 1; break; end
        end
        lat = cyc - ack_cyc;
        checks++;
        if (!ok || lat != 8 || busy_o) begin
            errors++;
            $display("FAIL %s_latency: seen=%0d latency=%0d busy=%0b, expected done after 8 cycles with busy=0",
                     name, ok, lat, busy_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width: done_o=%b after one cycle, expected 0", name, done_o);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, ds;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({ack_o, resp_o, busy_o, done_o} !== 4'b0000 || rdata_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack/resp/busy/done=%b rdata=%h, expected 0000 and 0",
                     {ack_o, resp_o, busy_o, done_o}, rdata_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        bus_read(5'h18, d, ds);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_out_list: read 0x18=%h, expected 0", d);
        end
        bus_read(5'h17, d, ds);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_in_list: read 0x17=%h, expected 0", d);
        end
    endtask

    task automatic test_low_window();
        logic [31:0] d, ds;
        int a;
        bus_write(5'h05, 32'h1234_5678, 4'hF, a);
        bus_read(5'h05, d, ds);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL low_window_read: read 0x05=%h, expected 0", d);
        end
    endtask

    task automatic test_byte_mask();
        logic [31:0] d, ds;
        int a;
        bus_write(5'h10, 32'hAABB_CCDD, 4'b0011, a);
        bus_read(5'h10, d, ds);
        checks++;
        if (d !== 32'h0000_CCDD) begin
            errors++;
            $display("FAIL byte_mask_low: read 0x10=%h, expected 0000ccdd", d);
        end
        bus_write(5'h10, 32'h1122_3344, 4'b1100, a);
        bus_read(5'h10, d, ds);
        checks++;
        if (d !== 32'h1122_CCDD) begin
            errors++;
            $display("FAIL byte_mask_high: read 0x10=%h, expected 1122ccdd", d);
        end
    endtask

    task automatic test_no_trigger();
        int a;
        bit seen = 0;
        for (int i = 0; i < 7; i++) begin
            bus_write(5'(5'h10 + i), 32'(100 + i), 4'hF, a);
            if (done_o || busy_o) seen = 1;
        end
        for (int n = 0; n < 15; n++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL no_trigger: done_o/busy_o asserted=1 after idx0..6 writes, expected 0");
        end
    endtask

    task automatic test_sort(input logic [31:0] vec [8], input logic [31:0] exp [8], input string name);
        logic [31:0] d, ds;
        int a;
        for (int i = 0; i < 8; i++) begin
            bus_write(5'(5'h10 + i), vec[i], 4'hF, a);
        end
        wait_done(a, name);
        for (int i = 0; i < 8; i++) begin
            bus_read(5'(5'h18 + i), d, ds);
            checks++;
            if (d !== exp[i]) begin
                errors++;
                $display("FAIL %s_out%0d: read=%0d expected=%0d", name, i, d, exp[i]);
            end
        end
    endtask

    task automatic test_signed();
        logic [31:0] d, ds;
        int a;
        bus_write(5'h10, 32'hFFFF_FFFF, 4'hF, a);
        for (int i = 1; i < 8; i++) begin
            bus_write(5'(5'h10 + i), 32'd0, 4'hF, a);
        end
        wait_done(a, "signed");
        bus_read(5'h1F, d, ds);
        checks++;
        if (d !== 32'hFFFF_FFFF || ds !== 32'd0) begin
            errors++;
            $display("FAIL cmp_mode_max: 0x1F unsigned=%h signed=%h, expected ffffffff and 0", d, ds);
        end
        bus_read(5'h18, d, ds);
        checks++;
        if (d !== 32'd0 || ds !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL cmp_mode_min: 0x18 unsigned=%h signed=%h, expected 0 and ffffffff", d, ds);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, ds;
        logic [31:0] vals [7] = '{32'd40, 32'd30, 32'd20, 32'd10, 32'd60, 32'd70, 32'd80};
        int a;
        int ack_at = -1;
        bit done_seen = 0;
        bit bad = 0;
        for (int i = 0; i < 7; i++) begin
            bus_write(5'(5'h10 + i), vals[i], 4'hF, a);
        end
        bus_write(5'h17, 32'd15, 4'hF, a);
        @(posedge clk_i); #2;
        bus_req_i = 1'b1; bus_we_i = 1'b0; bus_addr_bi = 32'h18;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk_i); #1;
            if (ack_o && busy_o) bad = 1;
            if (ack_o && !done_seen) bad = 1;
            if (done_o) done_seen = 1;
            if (ack_o) begin ack_at = cyc; break; end
        end
        bus_req_i = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (bad || (ack_at - a) != 9) begin
            errors++;
            $display("FAIL stall_ack: early_ack=%0b ack_delay=%0d, expected 0 and 9", bad, ack_at - a);
        end
        checks++;
        if (!resp_o || rdata_o !== 32'd10) begin
            errors++;
            $display("FAIL stall_read: resp=%0b data=%0d, expected 1 and 10", resp_o, rdata_o);
        end
        bus_write(5'h17, 32'd5, 4'hF, a);
        wait_done(a, "resort");
        bus_read(5'h18, d, ds);
        checks++;
        if (d !== 32'd5) begin
            errors++;
            $display("FAIL resort_min: read 0x18=%0d, expected 5", d);
        end
        bus_read(5'h1F, d, ds);
        checks++;
        if (d !== 32'd80) begin
            errors++;
            $display("FAIL resort_max: read 0x1F=%0d, expected 80", d);
        end
    endtask

    task automatic test_abandon();
        logic [31:0] d, ds;
        int a;
        bit acked = 0;
        bus_write(5'h17, 32'd7, 4'hF, a);
        @(negedge clk_i);
        bus_req_i = 1'b1; bus_we_i = 1'b1; bus_addr_bi = 32'h12;
        bus_wdata_bi = 32'h0000_DEAD; bus_be_bi = 4'hF;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk_i); #1;
            if (ack_o) acked = 1;
        end
        bus_req_i = 1'b0; bus_we_i = 1'b0;
        checks++;
        if (acked) begin
            errors++;
            $display("FAIL abandon_ack: ack_o=1 while busy, expected 0");
        end
        wait_done(a, "abandon");
        bus_read(5'h12, d, ds);
        checks++;
        if (d !== 32'd20) begin
            errors++;
            $display("FAIL abandon_data: read 0x12=%0d, expected 20", d);
        end
    endtask

    task automatic test_reset_mid_sort();
        logic [31:0] d, ds;
        logic [4:0] addrs [4] = '{5'h10, 5'h17, 5'h18, 5'h1F};
        int a;
        bus_write(5'h17, 32'd3, 4'hF, a);
        repeat (4) begin
            @(posedge clk_i); #1;
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_sort_busy: busy_o=%b in stage 3, expected 1", busy_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || ack_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_sort_reset: busy=%b done=%b ack=%b, expected 0 0 0", busy_o, done_o, ack_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], d, ds);
            checks++;
            if (d !== 32'd0) begin
                errors++;
                $display("FAIL mid_sort_clear: read %h=%h, expected 0", addrs[i], d);
            end
        end
    endtask

    logic [31:0] v1 [8] = '{32'd9, 32'd7, 32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd6};
    logic [31:0] e1 [8] = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    logic [31:0] v2 [8] = '{32'd51, 32'd160, 32'd4, 32'd77, 32'd194, 32'd223, 32'd13, 32'd84};
    logic [31:0] e2 [8] = '{32'd4, 32'd13, 32'd51, 32'd77, 32'd84, 32'd160, 32'd194, 32'd223};
    logic [31:0] v3 [8] = '{32'd123456789, 32'd987654321, 32'd567890123, 32'd109876543,
                            32'd203456789, 32'd345678901, 32'd789012345, 32'd198765432};
    logic [31:0] e3 [8] = '{32'd109876543, 32'd123456789, 32'd198765432, 32'd203456789,
                            32'd345678901, 32'd567890123, 32'd789012345, 32'd987654321};

    initial begin
        test_reset();
        test_low_window();
        test_byte_mask();
        test_no_trigger();
        test_sort(v1, e1, "sort_small");
        test_sort(v2, e2, "sort_bytes");
        test_sort(v3, e3, "sort_large");
        test_signed();
        test_back_to_back();
        test_abandon();
        test_reset_mid_sort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule
